life_readout: RTL and testbench

Raster readout engine for the life cell array: the read side of the array's per-cell write and scan load path. On a start request it snapshots the `alive` outputs of all columns into a shadow register in one cycle. It then streams the snapshot out one cell per transfer over a valid/ready handshake, in row-major raster order, for display or serial-link consumers. The array may keep evolving during the stream; the emitted frame always reflects the single generation captured at snapshot time.

---
 rtl/life_readout_if.sv | 25 ++
 rtl/life_readout.sv | 102 ++++++++++
 tb/tb_life_readout.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/life_readout_if.sv
// rtl/life_readout_if.sv - beat stream carrying one life cell per transfer
interface life_readout_if #(
  parameter int COLS = 4,
  parameter int ROWS = 4
);
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;

  logic          out_valid;
  logic          out_ready;
  logic          out_bit;
  logic [RW-1:0] out_row;
  logic [CW-1:0] out_col;
  logic          out_last;

  modport master (
    output out_valid, out_bit, out_row, out_col, out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid, out_bit, out_row, out_col, out_last,
    output out_ready
  );
endinterface

// File: rtl/life_readout.sv
// rtl/life_readout.sv - snapshots the life array and streams it out in raster order
module life_readout #(
  parameter int COLS = 4,
  parameter int ROWS = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [COLS*ROWS-1:0] alive_flat,
  input  logic                 start,
  life_readout_if.master       out,
  output logic                 busy,
  output logic                 frame_done
);
  localparam int N  = COLS * ROWS;
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, CAPTURE, SEND} state_t;

  state_t        state_q;
  logic [N-1:0]  shadow_q;
  logic [RW-1:0] row_q, row_d;
  logic [CW-1:0] col_q, col_d;
  logic          valid_q, last_q, last_d, busy_q, done_q;
  logic [IW-1:0] idx;
  logic          accept;

  assign accept = valid_q & out.out_ready;

  // Position of the beat that follows the current one in row-major order.
  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (col_q == CW'(COLS - 1)) begin
      col_d = '0;
      row_d = row_q + 1'b1;
    end else begin
      col_d = col_q + 1'b1;
    end
    last_d = (row_d == RW'(ROWS - 1)) && (col_d == CW'(COLS - 1));
    idx    = IW'(col_q) * IW'(ROWS) + IW'(row_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      shadow_q <= '0;
      row_q    <= '0;
      col_q    <= '0;
      valid_q  <= 1'b0;
      last_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= CAPTURE;
            busy_q  <= 1'b1;
          end
        end
        CAPTURE: begin
          shadow_q <= alive_flat;
          row_q    <= '0;
          col_q    <= '0;
          valid_q  <= 1'b1;
          last_q   <= (N == 1);
          state_q  <= SEND;
        end
        SEND: begin
          if (accept) begin
            if (last_q) begin
              state_q <= IDLE;
              valid_q <= 1'b0;
              last_q  <= 1'b0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              row_q   <= '0;
              col_q   <= '0;
            end else begin
              row_q  <= row_d;
              col_q  <= col_d;
              last_q <= last_d;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Gate with valid so stale shadow contents never show outside a frame.
  assign out.out_valid = valid_q;
  assign out.out_bit   = valid_q & shadow_q[idx];
  assign out.out_row   = row_q;
  assign out.out_col   = col_q;
  assign out.out_last  = last_q;
  assign busy          = busy_q;
  assign frame_done    = done_q;
endmodule

// File: tb/tb_life_readout.sv
// tb/tb_life_readout.sv - randomized directed bench for life_readout against a raster model
module tb_life_readout;
  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] alive0;
  logic        start0, busy0, done0;
  logic [5:0]  alive1;
  logic        start1, busy1, done1;
  int          n_tests = 0;
  int          n_fail  = 0;

  always #5 clk = ~clk;

  life_readout_if #(.COLS(4), .ROWS(4)) if0 ();
  life_readout_if #(.COLS(3), .ROWS(2)) if1 ();

  life_readout #(.COLS(4), .ROWS(4)) u0 (
    .clk(clk), .reset(reset), .alive_flat(alive0), .start(start0),
    .out(if0.master), .busy(busy0), .frame_done(done0)
  );

  life_readout #(.COLS(3), .ROWS(2)) u1 (
    .clk(clk), .reset(reset), .alive_flat(alive1), .start(start1),
    .out(if1.master), .busy(busy1), .frame_done(done1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Request a frame; returns at the negedge inside the CAPTURE cycle.
  task automatic kick(input logic [15:0] snap, input bit hold);
    @(negedge clk);
    alive0 = snap;
    start0 = 1'b1;
    @(negedge clk);
    start0 = hold;
    chk("capture", {done0, busy0, if0.out_valid}, 3'b010);
  endtask

  // Consume one 4x4 frame, comparing every visible beat with the raster model.
  task automatic stream(input logic [15:0] snap, input logic [15:0] after_v,
                        input bit rnd_ready, input bit junk, input bit hold);
    int b = 0;
    int cyc = 1;
    int guard = 0;
    int r, c;
    bit rdy;
    while (b < 16 && guard < 500) begin
      @(negedge clk);
      cyc++;
      guard++;
      alive0 = after_v;
      r = b / 4;
      c = b % 4;
      chk("valid", {31'd0, if0.out_valid}, 32'd1);
      chk("beat", {if0.out_bit, if0.out_row, if0.out_col, if0.out_last},
          {snap[c*4+r], 2'(r), 2'(c), (b == 15)});
      rdy = rnd_ready ? bit'($urandom_range(0, 1)) : 1'b1;
      if0.out_ready = rdy;
      if (junk) start0 = 1'($urandom_range(0, 1));
      if (rdy) b++;
    end
    chk("frame_timeout", {31'd0, (guard < 500)}, 32'd1);
    @(negedge clk);
    cyc++;
    start0 = hold;
    chk("done_pulse", {done0, busy0, if0.out_valid}, 3'b100);
    if (!rnd_ready) chk("frame_len", cyc, 32'd18);
    @(negedge clk);
    if (hold) chk("b2b_capture", {done0, busy0, if0.out_valid}, 3'b010);
    else      chk("done_once", {done0, busy0, if0.out_valid}, 3'b000);
  endtask

  initial begin
    logic [15:0] s1, s2;
    logic [5:0]  s6;
    reset = 1'b1;
    alive0 = '0;
    start0 = 1'b0;
    alive1 = '0;
    start1 = 1'b0;
    if0.out_ready = 1'b0;
    if1.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle_outputs", {done0, busy0, if0.out_valid, if0.out_bit, if0.out_row,
                           if0.out_col, if0.out_last}, 32'd0);
    end

    kick(16'h8421, 1'b0);
    stream(16'h8421, 16'h8421, 1'b0, 1'b0, 1'b0);

    kick(16'h8421, 1'b0);
    stream(16'h8421, 16'h8421, 1'b1, 1'b0, 1'b0);

    kick(16'hFFFF, 1'b0);
    stream(16'hFFFF, 16'h0000, 1'b0, 1'b0, 1'b0);

    s1 = 16'($urandom);
    kick(s1, 1'b0);
    stream(s1, 16'($urandom), 1'b1, 1'b1, 1'b0);

    s1 = 16'($urandom);
    s2 = 16'($urandom);
    kick(s1, 1'b1);
    stream(s1, s2, 1'b0, 1'b0, 1'b1);
    start0 = 1'b0;
    stream(s2, s2, 1'b1, 1'b0, 1'b0);

    s1 = 16'($urandom);
    kick(s1, 1'b0);
    if0.out_ready = 1'b1;
    repeat (8) @(negedge clk);
    chk("mid_position", {if0.out_row, if0.out_col}, {2'd1, 2'd3});
    reset = 1'b1;
    @(negedge clk);
    chk("mid_reset", {done0, busy0, if0.out_valid, if0.out_row, if0.out_col}, 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("no_done_after_reset", {done0, busy0, if0.out_valid}, 3'b000);
    end
    s1 = 16'($urandom);
    kick(s1, 1'b0);
    stream(s1, 16'($urandom), 1'b1, 1'b0, 1'b0);

    for (int k = 0; k < 2; k++) begin
      s6 = (k == 0) ? 6'b101101 : 6'($urandom);
      @(negedge clk);
      alive1 = s6;
      start1 = 1'b1;
      if1.out_ready = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
      chk("c32_capture", {busy1, if1.out_valid}, 2'b10);
      for (int b = 0; b < 6; b++) begin
        @(negedge clk);
        alive1 = ~s6;
        chk("c32_beat", {if1.out_valid, if1.out_bit, if1.out_row, if1.out_col, if1.out_last},
            {1'b1, s6[(b % 3) * 2 + b / 3], 1'(b / 3), 2'(b % 3), (b == 5)});
      end
      @(negedge clk);
      chk("c32_done", {done1, busy1, if1.out_valid}, 3'b100);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
